// File: rtl/video_mixer_sl.sv
// video_mixer_sl: native-path output mixer. Expands IN_BITS colour to 8 bits,
// applies optional scanline darkening on alternate lines, forces black on
// freeze, regenerates the pixel enable and builds DE from the blank inputs.

// Per-colour lane: expansion, freeze blanking, stage-1 register, scanline
// scaling and the CE_PIXEL-qualified output register.
module video_mixer_sl_lane #(
  parameter int IN_BITS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frz,
  input  logic               ce_out,
  input  logic               darken,
  input  logic [1:0]         mode,
  input  logic [IN_BITS-1:0] din,
  output logic [7:0]         dout
);
  logic [7:0] expd;
  logic [7:0] s1;
  logic [7:0] slv;

  // MSB-first replication of the input component, truncated to 8 bits
  for (genvar k = 0; k < 8; k++) begin : g_exp
    assign expd[7-k] = din[IN_BITS-1-(k % IN_BITS)];
  end

  // Stage 1: register expanded colour, black while frozen
  always_ff @(posedge clk) begin
    if (reset) s1 <= '0;
    else       s1 <= frz ? 8'h00 : expd;
  end

  // Scanline level: 75 %, 50 % or 25 % of the stage-1 value
  always_comb begin
    slv = s1;
    if (darken) begin
      case (mode)
        2'd1:    slv = s1 - {2'b00, s1[7:2]};
        2'd2:    slv = {1'b0, s1[7:1]};
        2'd3:    slv = {2'b00, s1[7:2]};
        default: slv = s1;
      endcase
    end
  end

  // Output register advances only on the regenerated pixel enable
  always_ff @(posedge clk) begin
    if (reset)       dout <= '0;
    else if (ce_out) dout <= slv;
  end
endmodule

module video_mixer_sl #(
  parameter int   IN_BITS          = 8,
  parameter logic SL_DEFAULT_PHASE = 1'b0
) (
  input  logic               CLK_VIDEO,
  input  logic               reset,
  input  logic               ce_pix,
  input  logic [IN_BITS-1:0] R,
  input  logic [IN_BITS-1:0] G,
  input  logic [IN_BITS-1:0] B,
  input  logic               HSync,
  input  logic               VSync,
  input  logic               HBlank,
  input  logic               VBlank,
  input  logic               freeze,
  input  logic [1:0]         scanlines,
  input  logic               sl_phase_sel,
  output logic               CE_PIXEL,
  output logic [7:0]         VGA_R,
  output logic [7:0]         VGA_G,
  output logic [7:0]         VGA_B,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_DE,
  output logic               line_odd,
  output logic               ce_is_clock
);
  localparam int LANES = 3;

  logic [1:0] frz_pipe;
  logic       frz;
  logic       hde, vde, hs, vs;
  logic       vs_d;
  logic       old_ce, ce_osc;
  logic       old_hs, old_vs2, old_hde;
  logic       darken;

  logic [LANES-1:0][IN_BITS-1:0] pix_in;
  logic [LANES-1:0][7:0]         pix_out;

  assign frz    = frz_pipe[1];
  assign pix_in = {R, G, B};
  assign darken = (scanlines != 2'd0) && (line_odd == (SL_DEFAULT_PHASE ^ sl_phase_sel));

  // Two-flop synchroniser for the asynchronous freeze request
  always_ff @(posedge CLK_VIDEO) begin
    if (reset) frz_pipe <= '0;
    else       frz_pipe <= {frz_pipe[0], freeze};
  end

  // Stage 1 sync/blank capture, every clock
  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      hde <= 1'b0;
      vde <= 1'b0;
      hs  <= 1'b0;
      vs  <= 1'b0;
    end else begin
      hde <= ~HBlank;
      vde <= ~VBlank;
      hs  <= HSync;
      vs  <= VSync;
    end
  end

  // ce_pix classification per frame and CE_PIXEL regeneration; a VS edge
  // latches the oscillation flag and restarts detection for the next frame
  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      old_ce      <= 1'b0;
      ce_osc      <= 1'b0;
      ce_is_clock <= 1'b0;
      vs_d        <= 1'b0;
      CE_PIXEL    <= 1'b0;
    end else begin
      old_ce <= ce_pix;
      vs_d   <= vs;
      if (vs & ~vs_d) begin
        ce_is_clock <= ce_osc;
        ce_osc      <= 1'b0;
      end else if (old_ce ^ ce_pix) begin
        ce_osc <= 1'b1;
      end
      CE_PIXEL <= ce_is_clock ? (~old_ce & ce_pix) : ce_pix;
    end
  end

  // Output syncs, line parity and DE; DE only moves on horizontal blank edges
  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      old_hs   <= 1'b0;
      old_vs2  <= 1'b0;
      old_hde  <= 1'b0;
      VGA_HS   <= 1'b0;
      VGA_VS   <= 1'b0;
      VGA_DE   <= 1'b0;
      line_odd <= 1'b0;
    end else if (CE_PIXEL) begin
      old_hs  <= hs;
      old_vs2 <= vs;
      old_hde <= hde;
      VGA_HS  <= hs;
      VGA_VS  <= vs;
      if (vs & ~old_vs2)     line_odd <= 1'b0;
      else if (hs & ~old_hs) line_odd <= ~line_odd;
      if (old_hde ^ hde)     VGA_DE   <= vde & hde;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    video_mixer_sl_lane #(.IN_BITS(IN_BITS)) u_lane (
      .clk    (CLK_VIDEO),
      .reset  (reset),
      .frz    (frz),
      .ce_out (CE_PIXEL),
      .darken (darken),
      .mode   (scanlines),
      .din    (pix_in[l]),
      .dout   (pix_out[l])
    );
  end

  assign VGA_R = pix_out[2];
  assign VGA_G = pix_out[1];
  assign VGA_B = pix_out[0];
endmodule

// File: tb/tb_video_mixer_sl.sv
// Bench for video_mixer_sl: an 8-bit and a 3-bit instance share control
// inputs; pixel results are checked through a two-deep expectation queue.
module tb_video_mixer_sl;
  logic       clk = 1'b0;
  logic       reset, ce_pix, HSync, VSync, HBlank, VBlank, freeze, sel;
  logic [1:0] sl;
  logic [7:0] R8, G8, B8;
  logic [2:0] R3;

  logic       ce8, hs8, vs8, de8, lo8, cic8;
  logic [7:0] r8o, g8o, b8o;
  logic       ce3, hs3, vs3, de3, lo3, cic3;
  logic [7:0] r3o, g3o, b3o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         chk;
    logic [7:0] r, g, b, r3;
    bit         lo, hs, vs, de;
  } exp_t;

  typedef struct {
    logic [7:0] r, g, b;
    logic [2:0] r3;
    logic [1:0] sl;
    bit         sel;
    logic [7:0] er, eg, eb, er3;
  } vec_t;

  exp_t q[$];
  vec_t tbl[10];
  bit   ce_mode = 1'b0;
  int   ph      = 0;
  bit   ce_prev = 1'b0;
  bit   ce_cur  = 1'b0;
  bit   de_exp  = 1'b1;
  bit   hb_s[11];
  bit   vb_s[11];
  bit   de_s[11];

  video_mixer_sl #(.IN_BITS(8)) dut8 (
    .CLK_VIDEO(clk), .reset(reset), .ce_pix(ce_pix),
    .R(R8), .G(G8), .B(B8),
    .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
    .freeze(freeze), .scanlines(sl), .sl_phase_sel(sel),
    .CE_PIXEL(ce8), .VGA_R(r8o), .VGA_G(g8o), .VGA_B(b8o),
    .VGA_HS(hs8), .VGA_VS(vs8), .VGA_DE(de8),
    .line_odd(lo8), .ce_is_clock(cic8)
  );

  video_mixer_sl #(.IN_BITS(3)) dut3 (
    .CLK_VIDEO(clk), .reset(reset), .ce_pix(ce_pix),
    .R(R3), .G(R3), .B(R3),
    .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
    .freeze(freeze), .scanlines(sl), .sl_phase_sel(sel),
    .CE_PIXEL(ce3), .VGA_R(r3o), .VGA_G(g3o), .VGA_B(b3o),
    .VGA_HS(hs3), .VGA_VS(vs3), .VGA_DE(de3),
    .line_odd(lo3), .ce_is_clock(cic3)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // one clock; ce_pix is either held high or run as a period-4 50 % clock
  task automatic tk();
    if (ce_mode) begin
      ce_pix = (ph < 2);
      ph     = (ph + 1) % 4;
    end else begin
      ce_pix = 1'b1;
    end
    ce_prev = ce_cur;
    ce_cur  = ce_pix;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic exp_t mk(bit c, logic [7:0] p8, logic [7:0] p3, bit lo);
    exp_t e;
    e.chk = c; e.r = p8; e.g = p8; e.b = p8; e.r3 = p3;
    e.lo = lo; e.hs = HSync; e.vs = VSync; e.de = de_exp;
    return e;
  endfunction

  // push expectation for the pixel being driven; pop the one now on VGA_*
  task automatic step(input exp_t e);
    exp_t p;
    q.push_back(e);
    tk();
    if (q.size() == 2) begin
      p = q.pop_front();
      chk("sb_hs", hs8, p.hs);
      chk("sb_vs", vs8, p.vs);
      chk("sb_de", de8, p.de);
      if (p.chk) begin
        chk("sb_r8", r8o, p.r);
        chk("sb_g8", g8o, p.g);
        chk("sb_b8", b8o, p.b);
        chk("sb_r3", r3o, p.r3);
        chk("sb_lo", lo8, p.lo);
      end
    end
  endtask

  task automatic run(input int n, input bit c, input logic [7:0] p8,
                     input logic [7:0] p3, input bit lo);
    for (int i = 0; i < n; i++) step(mk(c, p8, p3, lo));
  endtask

  task automatic hs_gap();
    HSync = 1'b1;
    run(2, 1'b0, 8'h00, 8'h00, 1'b0);
    HSync = 1'b0;
  endtask

  task automatic vs_pulse();
    VSync = 1'b1;
    repeat (6) tk();
    VSync = 1'b0;
    repeat (10) tk();
  endtask

  initial begin
    exp_t e;
    tbl[0] = '{8'hC8, 8'hC8, 8'hC8, 3'd5, 2'd0, 1'b0, 8'hC8, 8'hC8, 8'hC8, 8'hB6};
    tbl[1] = '{8'hC8, 8'hC8, 8'hC8, 3'd5, 2'd2, 1'b0, 8'h64, 8'h64, 8'h64, 8'h5B};
    tbl[2] = '{8'hC8, 8'hC8, 8'hC8, 3'd5, 2'd1, 1'b0, 8'h96, 8'h96, 8'h96, 8'h89};
    tbl[3] = '{8'hC8, 8'hC8, 8'hC8, 3'd5, 2'd3, 1'b0, 8'h32, 8'h32, 8'h32, 8'h2D};
    tbl[4] = '{8'hC8, 8'hC8, 8'hC8, 3'd5, 2'd2, 1'b1, 8'hC8, 8'hC8, 8'hC8, 8'hB6};
    tbl[5] = '{8'hFF, 8'h00, 8'h80, 3'd7, 2'd0, 1'b0, 8'hFF, 8'h00, 8'h80, 8'hFF};
    tbl[6] = '{8'h01, 8'h7F, 8'hFE, 3'd0, 2'd1, 1'b0, 8'h01, 8'h60, 8'hBF, 8'h00};
    tbl[7] = '{8'hFF, 8'h04, 8'h03, 3'd7, 2'd3, 1'b0, 8'h3F, 8'h01, 8'h00, 8'h3F};
    tbl[8] = '{8'h5A, 8'hA5, 8'h3C, 3'd2, 2'd0, 1'b0, 8'h5A, 8'hA5, 8'h3C, 8'h49};
    tbl[9] = '{8'h80, 8'h81, 8'h01, 3'd1, 2'd2, 1'b0, 8'h40, 8'h40, 8'h00, 8'h12};
    hb_s = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0};
    vb_s = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    de_s = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1};

    reset = 1'b1; ce_pix = 1'b1; HSync = 1'b0; VSync = 1'b0; HBlank = 1'b0;
    VBlank = 1'b0; freeze = 1'b0; sel = 1'b0; sl = 2'd0;
    R8 = 8'h00; G8 = 8'h00; B8 = 8'h00; R3 = 3'd0;
    repeat (3) tk();
    chk("reset_out8", {ce8, r8o, g8o, b8o, hs8, vs8, de8, lo8, cic8}, 32'h0);
    chk("reset_out3", {ce3, r3o, g3o, b3o, hs3, vs3, de3, lo3, cic3}, 32'h0);
    reset = 1'b0;

    // table: expansion and scanline levels on an even (darkened) line
    for (int i = 0; i < 10; i++) begin
      R8 = tbl[i].r; G8 = tbl[i].g; B8 = tbl[i].b; R3 = tbl[i].r3;
      sl = tbl[i].sl; sel = tbl[i].sel;
      e = mk(1'b1, tbl[i].er, tbl[i].er3, 1'b0);
      e.g = tbl[i].eg;
      e.b = tbl[i].eb;
      step(e);
      step(mk(1'b0, 8'h00, 8'h00, 1'b0));
    end

    // two VS edges settle the CE detector back into pass-through
    sl = 2'd0;
    vs_pulse();
    vs_pulse();
    chk("prime_cic", cic8, 1'b0);
    chk("prime_ce", ce8, 1'b1);

    // scanlines over four lines after VS, then modes 1/3 and phase select
    q.delete();
    R8 = 8'hC8; G8 = 8'hC8; B8 = 8'hC8; R3 = 3'd7; sl = 2'd2; sel = 1'b0;
    HSync = 1'b1; VSync = 1'b1;
    run(2, 1'b0, 8'h00, 8'h00, 1'b0);
    HSync = 1'b0; VSync = 1'b0;
    run(6, 1'b1, 8'h64, 8'h7F, 1'b0);
    hs_gap(); run(6, 1'b1, 8'hC8, 8'hFF, 1'b1);
    hs_gap(); run(6, 1'b1, 8'h64, 8'h7F, 1'b0);
    hs_gap(); run(6, 1'b1, 8'hC8, 8'hFF, 1'b1);
    hs_gap(); run(4, 1'b1, 8'h64, 8'h7F, 1'b0); run(1, 1'b0, 8'h00, 8'h00, 1'b0);
    sl = 2'd1; run(4, 1'b1, 8'h96, 8'hC0, 1'b0); run(1, 1'b0, 8'h00, 8'h00, 1'b0);
    sl = 2'd3; run(4, 1'b1, 8'h32, 8'h3F, 1'b0); run(1, 1'b0, 8'h00, 8'h00, 1'b0);
    sel = 1'b1; run(4, 1'b1, 8'hC8, 8'hFF, 1'b0); run(1, 1'b0, 8'h00, 8'h00, 1'b0);
    sl = 2'd0; sel = 1'b0;
    run(3, 1'b1, 8'hC8, 8'hFF, 1'b0);

    // freeze: two more live pixels, then black; syncs keep running
    freeze = 1'b1;
    run(2, 1'b1, 8'hC8, 8'hFF, 1'b0);
    run(4, 1'b1, 8'h00, 8'h00, 1'b0);
    hs_gap();
    run(4, 1'b1, 8'h00, 8'h00, 1'b1);
    freeze = 1'b0;
    run(2, 1'b1, 8'h00, 8'h00, 1'b1);
    run(4, 1'b1, 8'hC8, 8'hFF, 1'b1);

    // DE only follows HBlank edges, VBlank alone never moves it
    for (int i = 0; i < 11; i++) begin
      HBlank = hb_s[i]; VBlank = vb_s[i]; de_exp = de_s[i];
      step(mk(1'b1, 8'hC8, 8'hFF, 1'b1));
    end
    de_exp = 1'b1;
    run(2, 1'b1, 8'hC8, 8'hFF, 1'b1);

    // ce_pix as a 50 % clock: detector flips to edge mode
    ce_mode = 1'b1;
    repeat (8) tk();
    vs_pulse();
    repeat (20) tk();
    vs_pulse();
    chk("clk_cic", cic8, 1'b1);
    for (int i = 0; i < 16; i++) begin
      tk();
      chk("clk_ce_pulse", ce8, ce_cur & ~ce_prev);
    end

    // reset mid-line with everything active
    HSync = 1'b1;
    repeat (8) tk();
    chk("pre_rst_lo", lo8, 1'b1);
    chk("pre_rst_hs", hs8, 1'b1);
    chk("pre_rst_de", de8, 1'b1);
    chk("pre_rst_r", r8o, 8'hC8);
    chk("pre_rst_cic", cic8, 1'b1);
    reset = 1'b1;
    tk();
    chk("midrst_out8", {ce8, r8o, g8o, b8o, hs8, vs8, de8, lo8, cic8}, 32'h0);
    chk("midrst_out3", {ce3, r3o, g3o, b3o, hs3, vs3, de3, lo3, cic3}, 32'h0);
    reset = 1'b0; HSync = 1'b0; ce_mode = 1'b0;
    tk();
    chk("post_rst_ce", ce8, 1'b1);
    chk("post_rst_cic", cic8, 1'b0);
    chk("post_rst_lo", lo8, 1'b0);

    // back to a clock, then a held enable: detector drops out one frame later
    ce_mode = 1'b1;
    repeat (8) tk();
    vs_pulse();
    repeat (20) tk();
    vs_pulse();
    chk("sw_cic_on", cic8, 1'b1);
    ce_mode = 1'b0;
    repeat (4) tk();
    vs_pulse();
    chk("sw_cic_hold", cic8, 1'b1);
    vs_pulse();
    chk("sw_cic_off", cic8, 1'b0);
    tk();
    chk("sw_ce_pass", ce8, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/video_mixer_sl.md
# video_mixer_sl

Parametrised output mixer for the native (non-scandoubled) video path. It expands `IN_BITS`-wide colour to 8 bits and applies a selectable scanline darkening effect on alternate lines. It also handles freeze blanking, pixel-clock-enable regeneration and DE generation. It sits between the core video generator and the HDMI/VGA encoder, alongside or after the scandoubler path.

## Interface
Parameters:
- `IN_BITS`, 8: input bits per colour component, legal range 1..8.
- `SL_DEFAULT_PHASE`, 0: line parity darkened after reset when `sl_phase_sel`=0.

Ports:
- `CLK_VIDEO` in 1: video clock, at least 4x the pixel rate.
- `reset` in 1: reset, synchronous and active-high; the block has a single clock, `CLK_VIDEO`.
- `ce_pix` in 1: input pixel clock or clock enable.
- `R`, `G`, `B` in `IN_BITS` each: input colour.
- `HSync`, `VSync`, `HBlank`, `VBlank` in 1 each: positive pulses.
- `freeze` in 1: asynchronous freeze request; forces black while syncs keep running.
- `scanlines` in 2: 0 = off, 1 = 75 % level, 2 = 50 %, 3 = 25 %.
- `sl_phase_sel` in 1: 1 inverts `SL_DEFAULT_PHASE`.
- `CE_PIXEL` out 1: output pixel enable.
- `VGA_R`, `VGA_G`, `VGA_B` out 8 each: output colour.
- `VGA_HS`, `VGA_VS`, `VGA_DE` out 1 each: output sync and data enable.
- `line_odd` out 1: current output line parity.
- `ce_is_clock` out 1: `ce_pix` was detected toggling as a clock during the last frame.

## Operation
- **Freeze sync:** `freeze` passes through 2 flops to give `frz`. While `frz`=1, expanded colour is forced to 0. HS, VS and DE are unaffected.
- **Expansion:** each component is replicated MSB-first and truncated to 8 bits. For example, with `IN_BITS`=3, `abc` becomes `abcabcab`. With `IN_BITS`=1, the result is 0x00 or 0xFF. With `IN_BITS`=8, the value passes through unchanged.
- **Stage 1 (every clock):** registers expanded colour, `~HBlank`, `~VBlank`, `HSync` and `VSync` into `r`, `g`, `b`, `hde`, `vde`, `hs` and `vs`.
- **CE detection:**
  - `old_ce` <= `ce_pix`.
  - `ce_osc` is set on any `old_ce` ^ `ce_pix`.
  - On a rising edge of the stage-1 `vs`: `ce_is_clock` <= `ce_osc`, and `ce_osc` <= 0. If both happen in the same cycle, the clear wins.
  - `CE_PIXEL` <= `ce_is_clock` ? (~`old_ce` & `ce_pix`) : `ce_pix`.
- **Line parity (updated only when `CE_PIXEL`=1):**
  - `old_hs` <= `hs`; `old_vs2` <= `vs`.
  - On a `vs` rising edge, `line_odd` <= 0.
  - Otherwise, on an `hs` rising edge, `line_odd` toggles.
  - If both rise in the same pixel, the VS clear wins.
- **Scanline:** a line is darkened when `scanlines`≠0 and `line_odd` == (`SL_DEFAULT_PHASE` ^ `sl_phase_sel`). With input value v (8 bits, unsigned, no overflow possible):
  - mode 1 gives v - (v>>2).
  - mode 2 gives v>>1.
  - mode 3 gives v>>2.
- **Output stage (only when `CE_PIXEL`=1):**
  - `VGA_R/G/B` <= the scanline result from `r`/`g`/`b`.
  - `VGA_HS` <= `hs`; `VGA_VS` <= `vs`.
  - `old_hde` <= `hde`; when `old_hde` ^ `hde`, `VGA_DE` <= `vde` & `hde`. Otherwise `VGA_DE` holds, so DE changes only on horizontal blank edges.
- `scanlines` and `sl_phase_sel` are sampled at the output stage. A change takes effect on the next `CE_PIXEL`, mid-line if necessary.

## Timing
- **Reset values:** `CE_PIXEL`, `VGA_R/G/B`, `VGA_HS`, `VGA_VS`, `VGA_DE`, `line_odd` and `ce_is_clock` are all 0. All internal state (`ce_osc`, `old_*`, `frz` pipeline, stage 1) is also 0.
- **Reset mid-frame:** the block restarts in pass-through CE mode. The first valid `ce_is_clock` appears after the next full VS-to-VS interval.
- **Data latency:** a pixel present on the inputs while `ce_pix`=1 (pass-through mode) appears on `VGA_*` 2 `CLK_VIDEO` cycles later, and is qualified by `CE_PIXEL` high in the preceding cycle.
- **Edge mode:** `CE_PIXEL` is a one-cycle pulse, 1 clock after each `ce_pix` rising edge.
- **Freeze latency:** 3 clocks from `freeze` to black stage-1 data.
- **Line parity:** `line_odd` changes 1 clock after the `CE_PIXEL` that sees the HS edge. The first pixel of a new line already uses the new parity.

## Test plan
- **`IN_BITS`=3 expansion:** R=3'b101 with `scanlines`=0 -> `VGA_R`=0xB6. R=3'b111 -> 0xFF. R=0 -> 0x00.
- **Scanlines:** constant 0xC8 input, `scanlines`=2, `sl_phase_sel`=0, `SL_DEFAULT_PHASE`=0, 4 lines after VS -> lines 0 and 2 output 0x64, lines 1 and 3 output 0xC8. Modes 1 and 3 on the same input give 0x96 and 0x32.
- **CE detection:** `ce_pix` toggling as a 50 % clock for one full frame -> `ce_is_clock`=1 after the second VS rise, and `CE_PIXEL` pulses 1 cycle per `ce_pix` period. Switching to a 1-cycle enable -> `ce_is_clock` returns to 0 after the following VS.
- **Freeze:** assert `freeze` mid-line -> colour reaches 0 within 3 clocks plus the next `CE_PIXEL`. HS, VS and DE timing stay identical to an unfrozen reference frame.
- **DE:** VBlank rises while HBlank=0 -> `VGA_DE` stays 1 until the next HBlank edge, then goes to 0.
- **Reset:** assert `reset` for 1 cycle mid-line with all outputs active -> all outputs read 0 on the next cycle. `line_odd`=0 and `ce_is_clock`=0 after reset.
